// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
//  Module      : mux4_rr_arbiter_pkg
//  Description : Shared types and round-robin pick helper for 4-way arbiters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan from the farthest offset back to start so the nearest set bit wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] start);
    pick_t            r;
    logic [SEL_W-1:0] i;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      i = start + SEL_W'(k);
      if (req[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_mux4.sv
// ============================================================================
//  Module      : mux4_rr_arbiter_mux4
//  Description : WIDTH-bit 4:1 selection mux shared by the arbiter datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter_mux4
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a0;
    case (s)
      2'd0: y = a0;
      2'd1: y = a1;
      2'd2: y = a2;
      2'd3: y = a3;
      default: y = a0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
//  Module      : mux4_rr_arbiter
//  Description : Round-robin arbiter over four requesters feeding a registered
//                valid/ready output through a shared 4:1 mux.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_src
);

  localparam logic [N_REQ-1:0] C_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_src;

  logic             w_accept;
  logic [N_REQ-1:0] w_gnt;
  logic [SEL_W-1:0] w_start;
  pick_t            w_pick;
  logic [WIDTH-1:0] w_mux_y;

  // On an accept cycle the accepted requester is masked and the search
  // begins just past it, so back-to-back winners rotate fairly.
  always_comb begin
    w_accept = (r_state == HOLD) && out_ready;
    w_gnt    = w_accept ? (C_ONE << r_src) : '0;
    w_start  = w_accept ? (r_src + SEL_W'(1)) : r_ptr;
    w_pick   = rr_pick(req & ~w_gnt, w_start);
  end

  mux4_rr_arbiter_mux4 #(
    .WIDTH (WIDTH)
  ) u_mux4 (
    .a0 (a0),
    .a1 (a1),
    .a2 (a2),
    .a3 (a3),
    .s  (w_pick.idx),
    .y  (w_mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      if (w_accept) begin
        r_ptr <= w_start;
      end
      if ((r_state == IDLE) || w_accept) begin
        if (w_pick.found) begin
          r_state <= HOLD;
          r_data  <= w_mux_y;
          r_src   <= w_pick.idx;
        end else begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign gnt       = w_gnt;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
//  Module      : tb_mux4_rr_arbiter
//  Description : Directed self-checking bench for mux4_rr_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] a0, a1, a2, a3;
  logic [3:0]       gnt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;

  int n_checks;
  int n_fail;

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({out_valid, out_data, out_src, gnt} !== {1'b0, 4'h0, 2'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b data=%h src=%0d gnt=%b, want 0/0/0/0000",
               out_valid, out_data, out_src, gnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({out_valid, gnt} !== 5'b0) begin
        n_fail++;
        $display("FAIL idle_no_req cyc%0d: got valid=%b gnt=%b, want 0 0000", i, out_valid, gnt);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100; a2 = 4'hA; out_ready = 1'b1;
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle_gnt: got %b want 0000", gnt);
    end
    tick();
    n_checks++;
    if ({out_valid, out_data, out_src, gnt} !== {1'b1, 4'hA, 2'd2, 4'b0100}) begin
      n_fail++;
      $display("FAIL single_hold: got valid=%b data=%h src=%0d gnt=%b, want 1/A/2/0100",
               out_valid, out_data, out_src, gnt);
    end
    tick();
    req = 4'b0000;
    n_checks++;
    if ({out_valid, gnt} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_after: got valid=%b gnt=%b, want 0 0000", out_valid, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src;
    apply_reset();
    a0 = 4'd1; a1 = 4'd2; a2 = 4'd3; a3 = 4'd4;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_src = 2'(i % 4);
      n_checks++;
      if ({out_valid, out_src, out_data, gnt} !==
          {1'b1, exp_src, 4'(exp_src + 1), 4'b0001 << exp_src}) begin
        n_fail++;
        $display("FAIL rr_seq cyc%0d: got valid=%b src=%0d data=%0d gnt=%b, want 1 src=%0d data=%0d",
                 i, out_valid, out_src, out_data, gnt, exp_src, exp_src + 1);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    apply_reset();
    req = 4'b0001; a0 = 4'd5; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({out_valid, out_data, out_src, gnt} !== {1'b1, 4'd5, 2'd0, 4'b0000}) begin
        n_fail++;
        $display("FAIL stall cyc%0d: got valid=%b data=%0d src=%0d gnt=%b, want 1/5/0/0000",
                 i, out_valid, out_data, out_src, gnt);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_release_gnt: got %b want 0001", gnt);
    end
    tick();
    req = 4'b0000;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    a0 = 4'h6; a3 = 4'h9;
    req = 4'b1000; out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_src, gnt} !== {2'd3, 4'b1000}) begin
      n_fail++;
      $display("FAIL wrap_first: got src=%0d gnt=%b want 3 1000", out_src, gnt);
    end
    req = 4'b1001;
    tick();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd0, 4'h6}) begin
      n_fail++;
      $display("FAIL wrap_to0: got valid=%b src=%0d data=%h want 1 0 6", out_valid, out_src, out_data);
    end
    tick();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd3, 4'h9}) begin
      n_fail++;
      $display("FAIL wrap_to3: got valid=%b src=%0d data=%h want 1 3 9", out_valid, out_src, out_data);
    end
    req = 4'b0000;
  endtask

  task automatic test_lone();
    logic exp_v;
    apply_reset();
    req = 4'b0010; a1 = 4'h7; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_v = (i % 2 == 0);
      n_checks++;
      if ({out_valid, gnt} !== {exp_v, exp_v ? 4'b0010 : 4'b0000}) begin
        n_fail++;
        $display("FAIL lone cyc%0d: got valid=%b gnt=%b want valid=%b", i, out_valid, gnt, exp_v);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    req = 4'b0100; a2 = 4'hA; a0 = 4'h3; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out_src} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL midhold_setup: got valid=%b src=%0d want 1 2", out_valid, out_src);
    end
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, gnt, out_data} !== {1'b0, 4'b0000, 4'h0}) begin
      n_fail++;
      $display("FAIL midhold_reset: got valid=%b gnt=%b data=%h want 0 0000 0", out_valid, gnt, out_data);
    end
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    n_checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd0, 4'h3}) begin
      n_fail++;
      $display("FAIL midhold_restart: got valid=%b src=%0d data=%h want 1 0 3", out_valid, out_src, out_data);
    end
    req = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_lone();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
